// File: rtl/output_subsystem.sv
// Reads N words from storage, converts each to unsigned decimal ASCII and sends
// the characters over UART 8N1: words separated by spaces, then CR LF.
module output_subsystem #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        w_en_output,
  input  logic [7:0]  start_addr,
  input  logic [8:0]  word_count,
  output logic [7:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        uart_tx_pin,
  output logic        busy,
  output logic        done
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);

  typedef enum logic [2:0] {
    StIdle, StRead, StConv, StSendDig, StSendSep, StSendCr, StSendLf, StFinish
  } state_e;

  state_e          state_q;
  logic [7:0]      base_q;
  logic [8:0]      count_q;
  logic [8:0]      idx_q;
  logic [7:0]      rd_addr_q;
  logic            rd_wait_q;
  logic [31:0]     bin_q;
  logic [39:0]     bcd_q;
  logic [4:0]      conv_cnt_q;
  logic [3:0]      dig_idx_q;
  logic            started_q;
  logic            busy_q;
  logic            done_q;

  // One-byte holding buffer lets the next character be prepared while the
  // current frame is on the line, so frames follow back to back.
  logic [7:0]      buf_q;
  logic            buf_vld_q;
  logic            tx_act_q;
  logic [9:0]      tx_shift_q;
  logic [3:0]      tx_bit_q;
  logic [CntW-1:0] tx_cnt_q;
  logic            tx_pin_q;

  logic [31:0]     bin_d;
  logic [39:0]     bcd_d;
  logic [39:0]     bcd_adj;
  logic [3:0]      cur_dig;
  logic            dig_emit;
  logic            tx_stop_end;
  logic            more_words;

  // One double-dabble step: add 3 to every digit >= 5, then shift left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
  end

  always_comb begin
    cur_dig     = bcd_q[{dig_idx_q, 2'b00} +: 4];
    // Leading zeros are skipped, but the units digit is always sent.
    dig_emit    = started_q || (cur_dig != 4'd0) || (dig_idx_q == 4'd0);
    tx_stop_end = tx_act_q && (tx_bit_q == 4'd9) && (tx_cnt_q == CntMax);
    more_words  = (idx_q + 9'd1) < count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      base_q     <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      rd_addr_q  <= '0;
      rd_wait_q  <= 1'b0;
      bin_q      <= '0;
      bcd_q      <= '0;
      conv_cnt_q <= '0;
      dig_idx_q  <= '0;
      started_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      buf_q      <= '0;
      buf_vld_q  <= 1'b0;
      tx_act_q   <= 1'b0;
      tx_shift_q <= '1;
      tx_bit_q   <= '0;
      tx_cnt_q   <= '0;
      tx_pin_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;

      // Byte transmitter: frame = {stop, data[7:0], start}, shifted out LSB first.
      if (tx_act_q) begin
        if (tx_cnt_q == CntMax) begin
          tx_cnt_q <= '0;
          if (tx_bit_q == 4'd9) begin
            if (buf_vld_q) begin
              tx_shift_q <= {1'b1, buf_q, 1'b0};
              tx_pin_q   <= 1'b0;
              tx_bit_q   <= '0;
              buf_vld_q  <= 1'b0;
            end else begin
              tx_act_q <= 1'b0;
              tx_pin_q <= 1'b1;
            end
          end else begin
            tx_shift_q <= {1'b1, tx_shift_q[9:1]};
            tx_pin_q   <= tx_shift_q[1];
            tx_bit_q   <= tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_q <= tx_cnt_q + 1'b1;
        end
      end else if (buf_vld_q) begin
        tx_act_q   <= 1'b1;
        tx_shift_q <= {1'b1, buf_q, 1'b0};
        tx_pin_q   <= 1'b0;
        tx_bit_q   <= '0;
        tx_cnt_q   <= '0;
        buf_vld_q  <= 1'b0;
      end

      // Job sequencer; only loads the buffer while it is empty.
      unique case (state_q)
        StIdle: begin
          if (w_en_output) begin
            base_q  <= start_addr;
            count_q <= word_count;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            if (word_count == 9'd0) begin
              state_q <= StSendCr;
            end else begin
              rd_addr_q <= start_addr;
              rd_wait_q <= 1'b1;
              state_q   <= StRead;
            end
          end
        end
        StRead: begin
          if (rd_wait_q) begin
            rd_wait_q <= 1'b0;
          end else begin
            bin_q      <= rd_data;
            bcd_q      <= '0;
            conv_cnt_q <= '0;
            state_q    <= StConv;
          end
        end
        StConv: begin
          bin_q      <= bin_d;
          bcd_q      <= bcd_d;
          conv_cnt_q <= conv_cnt_q + 5'd1;
          if (conv_cnt_q == 5'd31) begin
            dig_idx_q <= 4'd9;
            started_q <= 1'b0;
            state_q   <= StSendDig;
          end
        end
        StSendDig: begin
          if (!dig_emit || !buf_vld_q) begin
            if (dig_emit) begin
              buf_q     <= {4'h3, cur_dig};
              buf_vld_q <= 1'b1;
              started_q <= 1'b1;
            end
            if (dig_idx_q == 4'd0) begin
              state_q <= StSendSep;
            end else begin
              dig_idx_q <= dig_idx_q - 4'd1;
            end
          end
        end
        StSendSep: begin
          if (!more_words) begin
            state_q <= StSendCr;
          end else if (!buf_vld_q) begin
            buf_q     <= 8'h20;
            buf_vld_q <= 1'b1;
            idx_q     <= idx_q + 9'd1;
            rd_addr_q <= base_q + idx_q[7:0] + 8'd1;
            rd_wait_q <= 1'b1;
            state_q   <= StRead;
          end
        end
        StSendCr: begin
          if (!buf_vld_q) begin
            buf_q     <= 8'h0D;
            buf_vld_q <= 1'b1;
            state_q   <= StSendLf;
          end
        end
        StSendLf: begin
          if (!buf_vld_q) begin
            buf_q     <= 8'h0A;
            buf_vld_q <= 1'b1;
            state_q   <= StFinish;
          end
        end
        StFinish: begin
          if (tx_stop_end && !buf_vld_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rd_addr     = rd_addr_q;
  assign uart_tx_pin = tx_pin_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_output_subsystem.sv
// Bench for output_subsystem: decodes the UART line at mid-bit and compares the
// byte stream, frame timing and handshakes against a decimal-formatting model.
module tb_output_subsystem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w_en_output;
  logic [7:0]  start_addr;
  logic [8:0]  word_count;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        uart_tx_pin;
  logic        busy;
  logic        done;

  logic [31:0] mem [256];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  int unsigned cyc = 0;
  logic [7:0]  rx_q[$];
  int unsigned rx_start_q[$];
  bit          rx_ok_q[$];
  logic [7:0]  addr_q[$];
  logic [7:0]  exp_q[$];
  int          done_cnt = 0;
  int unsigned done_cyc = 0;
  int          busy_err = 0;
  bit          job_active = 1'b0;
  bit          in_frame = 1'b0;

  output_subsystem #(
    .CLK_FREQ (1000),
    .BAUD_RATE(100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .w_en_output(w_en_output),
    .start_addr (start_addr),
    .word_count (word_count),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .uart_tx_pin(uart_tx_pin),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Line monitor: frames are sampled every clock; each bit must hold 10 clocks.
  initial begin
    int          pos;
    int unsigned fstart;
    bit          shape_ok;
    logic        bit_val;
    logic [7:0]  data;
    logic [7:0]  last_addr;
    pos = 0; fstart = 0; shape_ok = 1'b1; bit_val = 1'b1; data = '0; last_addr = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        in_frame  = 1'b0;
        last_addr = rd_addr;
      end else begin
        if (rd_addr !== last_addr) begin
          addr_q.push_back(rd_addr);
          last_addr = rd_addr;
        end
        if (done === 1'b1) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (job_active && done !== 1'b1 && busy !== 1'b1) busy_err++;
        if (!in_frame && uart_tx_pin === 1'b0) begin
          in_frame = 1'b1;
          pos      = 0;
          fstart   = cyc;
          shape_ok = 1'b1;
          data     = '0;
        end
        if (in_frame) begin
          if (pos % 10 == 0) bit_val = uart_tx_pin;
          else if (uart_tx_pin !== bit_val) shape_ok = 1'b0;
          if (pos % 10 == 5) begin
            if (pos / 10 == 0 && uart_tx_pin !== 1'b0) shape_ok = 1'b0;
            else if (pos / 10 >= 1 && pos / 10 <= 8) data[pos/10-1] = uart_tx_pin;
            else if (pos / 10 == 9 && uart_tx_pin !== 1'b1) shape_ok = 1'b0;
          end
          pos++;
          if (pos == 100) begin
            rx_q.push_back(data);
            rx_start_q.push_back(fstart);
            rx_ok_q.push_back(shape_ok);
            in_frame = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal text of each word, space separated, then CR LF.
  task automatic build_expected(input logic [7:0] sa, input int n);
    string s;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      logic [7:0] a;
      a = sa + 8'(i);
      s = $sformatf("%0d", mem[a]);
      for (int j = 0; j < s.len(); j++) exp_q.push_back(s[j]);
      if (i < n - 1) exp_q.push_back(8'h20);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic clear_monitor();
    rx_q.delete();
    rx_start_q.delete();
    rx_ok_q.delete();
    addr_q.delete();
    done_cnt = 0;
    busy_err = 0;
  endtask

  task automatic pulse_start(input logic [7:0] sa, input logic [8:0] n);
    @(posedge clk); #1;
    w_en_output = 1'b1;
    start_addr  = sa;
    word_count  = n;
    @(posedge clk); #1;
    w_en_output = 1'b0;
  endtask

  task automatic run_job(input string name, input logic [7:0] sa, input logic [8:0] n,
                         input bit dbl);
    build_expected(sa, int'(n));
    @(posedge clk); #1;
    clear_monitor();
    chk({name, "_idle_before"}, uart_tx_pin, 1'b1);
    pulse_start(sa, n);
    chk({name, "_busy_set"}, busy, 1'b1);
    job_active = 1'b1;
    if (dbl) begin
      repeat (3) @(posedge clk);
      #1;
      pulse_start(8'd9, 9'd5);
    end
    for (int k = 0; k < 8000 && done_cnt == 0; k++) begin
      @(posedge clk); #1;
    end
    chk({name, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    job_active = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk({name, "_done_once"}, done_cnt, 1);
    chk({name, "_busy_high"}, busy_err, 0);
    chk({name, "_busy_clear"}, busy, 1'b0);
    chk({name, "_idle_after"}, uart_tx_pin, 1'b1);
    chk({name, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      chk($sformatf("%s_byte%0d", name, i), rx_q[i], exp_q[i]);
      chk($sformatf("%s_shape%0d", name, i), rx_ok_q[i], 1'b1);
      if (i > 0) chk($sformatf("%s_gap%0d", name, i), rx_start_q[i] - rx_start_q[i-1], 100);
    end
    if (rx_start_q.size() > 0)
      chk({name, "_done_time"}, done_cyc, rx_start_q[rx_start_q.size()-1] + 100);
  endtask

  initial begin
    logic [7:0] sa;
    logic [8:0] n;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst_n       = 1'b0;
    w_en_output = 1'b0;
    start_addr  = '0;
    word_count  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pin", uart_tx_pin, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_addr", rd_addr, 8'd0);
    rst_n = 1'b1;

    mem[0] = 32'd12; mem[1] = 32'd0; mem[2] = 32'd305;
    run_job("three", 8'd0, 9'd3, 1'b0);

    mem[5] = 32'hFFFF_FFFF;
    run_job("max", 8'd5, 9'd1, 1'b0);

    run_job("zero", 8'd17, 9'd0, 1'b0);
    chk("zero_no_addr", addr_q.size(), 0);

    mem[255] = 32'd7; mem[0] = 32'd8;
    run_job("wrap", 8'd255, 9'd2, 1'b0);
    chk("wrap_naddr", addr_q.size(), 2);
    if (addr_q.size() == 2) begin
      chk("wrap_addr0", addr_q[0], 8'd255);
      chk("wrap_addr1", addr_q[1], 8'd0);
    end

    mem[0] = 32'd12;
    run_job("dbl", 8'd0, 9'd3, 1'b1);

    for (int r = 0; r < 3; r++) begin
      sa = 8'($urandom_range(0, 255));
      n  = 9'($urandom_range(1, 4));
      for (int i = 0; i < int'(n); i++) mem[8'(sa + 8'(i))] = $urandom >> $urandom_range(0, 31);
      run_job($sformatf("rand%0d", r), sa, n, 1'b0);
    end

    // Abort mid-data-bit with an asynchronous reset.
    pulse_start(8'd0, 9'd3);
    for (int k = 0; k < 1000 && !in_frame; k++) begin
      @(posedge clk); #1;
    end
    chk("abort_frame_started", in_frame, 1'b1);
    repeat (25) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_pin", uart_tx_pin, 1'b1);
    chk("abort_busy", busy, 1'b0);
    #20;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    mem[4] = 32'd1000000;
    mem[5] = 32'd42;
    run_job("after_rst", 8'd4, 9'd2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
